// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_sequencer
//  Function : Collects ALU operand A, operand B and the 4-bit control word
//             from switches, one value per debounced button press, and holds
//             them on registered outputs for the ALU.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_operand_sequencer #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    input  logic             clr,
    input  logic [WIDTH-1:0] sw_data,
    input  logic [3:0]       sw_op,
    output logic [WIDTH-1:0] a_operand,
    output logic [WIDTH-1:0] b_operand,
    output logic [3:0]       alu_control,
    output logic             op_valid,
    output logic [1:0]       state,
    output logic             press
);

    // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
    localparam int CNT_W_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOAD_A  = 2'b00,
        S_LOAD_B  = 2'b01,
        S_LOAD_OP = 2'b10,
        S_RUN     = 2'b11
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             stable_dly_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic             valid_q;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next state: accept a new level only after it has persisted.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == C_CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d    = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers plus one-cycle delayed level for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    // Rising edge of the accepted level only; releases are ignored.
    assign press = stable_q & ~stable_dly_q;

    // Entry sequencer: each press captures the next value; clr wins over press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else if (clr) begin
            state_q <= S_LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else if (press) begin
            case (state_q)
                S_LOAD_A: begin
                    a_q     <= sw_data;
                    state_q <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    b_q     <= sw_data;
                    state_q <= S_LOAD_OP;
                end
                S_LOAD_OP: begin
                    op_q    <= sw_op;
                    valid_q <= 1'b1;
                    state_q <= S_RUN;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= S_LOAD_A;
                end
            endcase
        end
    end

    assign a_operand   = a_q;
    assign b_operand   = b_q;
    assign alu_control = op_q;
    assign op_valid    = valid_q;
    assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_sequencer
//  Function : Self-checking bench for alu_operand_sequencer with a
//             behavioural reference model (history-window debounce model and
//             entry-step counter).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_operand_sequencer;

    localparam int WIDTH = 3;
    localparam int DC    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             btn = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] sw_data = '0;
    logic [3:0]       sw_op = '0;
    logic [WIDTH-1:0] a_operand;
    logic [WIDTH-1:0] b_operand;
    logic [3:0]       alu_control;
    logic             op_valid;
    logic [1:0]       state;
    logic             press;

    int errors = 0;
    int checks = 0;

    alu_operand_sequencer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .clr(clr),
        .sw_data(sw_data), .sw_op(sw_op),
        .a_operand(a_operand), .b_operand(b_operand),
        .alu_control(alu_control), .op_valid(op_valid),
        .state(state), .press(press)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. The synchronized button value seen on edge k is the
    // raw button sampled two edges earlier. A new level is accepted when the
    // last DC synchronized values all differ from the accepted level.
    // ------------------------------------------------------------------
    bit             samp[$];
    bit             syncq[$];
    bit             m_stable = 1'b0;
    bit             m_press = 1'b0;
    int             m_step = 0;
    logic [WIDTH-1:0] m_a = '0;
    logic [WIDTH-1:0] m_b = '0;
    logic [3:0]     m_op = '0;
    bit             m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp.delete(); syncq.delete();
            m_stable = 0; m_press = 0; m_step = 0;
            m_a = '0; m_b = '0; m_op = '0; m_valid = 0;
        end else begin
            bit s, all_diff, old;
            if (clr) begin
                m_step = 0; m_a = '0; m_b = '0; m_op = '0; m_valid = 0;
            end else if (m_press) begin
                case (m_step)
                    0: begin m_a = sw_data; m_step = 1; end
                    1: begin m_b = sw_data; m_step = 2; end
                    2: begin m_op = sw_op; m_valid = 1; m_step = 3; end
                    default: begin m_valid = 0; m_step = 0; end
                endcase
            end
            s = (samp.size() >= 2) ? samp[samp.size()-2] : 1'b0;
            syncq.push_back(s);
            all_diff = (syncq.size() >= DC);
            if (all_diff)
                for (int i = 1; i <= DC; i++)
                    if (syncq[syncq.size()-i] == m_stable) all_diff = 0;
            old = m_stable;
            if (all_diff) m_stable = ~m_stable;
            m_press = m_stable & ~old;
            samp.push_back(btn);
            if (samp.size() > 32) void'(samp.pop_front());
            if (syncq.size() > 32) void'(syncq.pop_front());
        end
    end

    function automatic logic [16:0] model_vec();
        return {m_a, m_b, m_op, m_valid, m_step[1:0], m_press};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {a_operand, b_operand, alu_control, op_valid, state, press};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Clean press stimulus: hold high, then release long enough to settle.
    task automatic do_press(input int hi, input logic [WIDTH-1:0] d, input logic [3:0] o);
        sw_data = d; sw_op = o; btn = 1'b1;
        repeat (hi) tick();
        btn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 17'd0) begin
            errors++; $display("FAIL reset_async: got %h expected 0", dut_vec());
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (dut_vec() !== 17'd0 || model_vec() !== 17'd0) begin
                errors++; $display("FAIL reset_hold: got %h model %h expected 0", dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        int npress = 0;
        sw_data = 3'b101; btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();  // now past edge i
            if (press) npress++;
            checks++;
            if (press !== (i == 5) || state !== ((i >= 6) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL clean_timing edge %0d: press=%b state=%b expected press=%b state=%b",
                                   i, press, state, (i == 5), (i >= 6) ? 2'b01 : 2'b00);
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL clean_model edge %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            if (i == 9) btn = 1'b0;
        end
        checks++;
        if (a_operand !== 3'b101 || npress != 1) begin
            errors++; $display("FAIL clean_result: a=%b presses=%0d expected a=101 presses=1", a_operand, npress);
        end
    endtask

    task automatic test_bounce();
        int npress = 0;
        sw_data = 3'b110;
        btn = 1; tick(); tick();
        btn = 0; tick();
        btn = 1; tick(); tick();
        btn = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (press) npress++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL bounce_model: got %h expected %h", dut_vec(), model_vec());
            end
        end
        checks++;
        if (npress != 0 || state !== 2'b01) begin
            errors++; $display("FAIL bounce_filter: presses=%0d state=%b expected 0 and 01", npress, state);
        end
        btn = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (press) npress++;
            if (i == 7) btn = 0;
        end
        checks++;
        if (npress != 1 || state !== 2'b10 || b_operand !== 3'b110) begin
            errors++; $display("FAIL bounce_clean: presses=%0d state=%b b=%b expected 1, 10, 110", npress, state, b_operand);
        end
    endtask

    task automatic test_clr_press();
        int seen = 0;
        sw_op = 4'b1111; btn = 1;
        for (int i = 0; i < 12 && seen == 0; i++) begin
            tick();
            if (press) begin
                seen = 1;
                clr = 1;
                tick();
                clr = 0;
            end
        end
        btn = 0;
        checks++;
        if (seen == 0) begin
            errors++; $display("FAIL clr_press_timeout: press=0 expected 1 within 12 cycles");
        end
        checks++;
        if (dut_vec() !== 17'd0 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL clr_press: got %h model %h expected 0", dut_vec(), model_vec());
        end
        repeat (10) tick();
    endtask

    task automatic test_full_sequence();
        do_press(6, 3'b011, 4'b1010);
        do_press(6, 3'b010, 4'b1010);
        do_press(6, 3'b111, 4'b0000);
        checks++;
        if ({a_operand, b_operand, alu_control, op_valid, state} !== {3'b011, 3'b010, 4'b0000, 1'b1, 2'b11}) begin
            errors++; $display("FAIL full_run: got %h expected %h",
                               {a_operand, b_operand, alu_control, op_valid, state},
                               {3'b011, 3'b010, 4'b0000, 1'b1, 2'b11});
        end
        checks++;
        if (3'(a_operand + b_operand) !== 3'b101) begin
            errors++; $display("FAIL full_alu_sum: got %b expected 101", 3'(a_operand + b_operand));
        end
        do_press(6, 3'b000, 4'b0110);
        checks++;
        if ({a_operand, b_operand, alu_control, op_valid, state} !== {3'b011, 3'b010, 4'b0000, 1'b0, 2'b00}) begin
            errors++; $display("FAIL full_wrap: got %h expected %h",
                               {a_operand, b_operand, alu_control, op_valid, state},
                               {3'b011, 3'b010, 4'b0000, 1'b0, 2'b00});
        end
    endtask

    task automatic test_switch_changes();
        int npress = 0;
        btn = 1;
        for (int i = 0; i < 40; i++) begin
            // press is high in this cycle exactly when the capture edge is next
            sw_data = press ? 3'b110 : 3'($urandom_range(0, 7) & 3'b001);
            tick();
            if (press) npress++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL switch_model: got %h expected %h", dut_vec(), model_vec());
            end
        end
        btn = 0;
        repeat (10) begin sw_data = 3'($urandom_range(0, 7)); tick(); end
        checks++;
        if (npress != 1 || state !== 2'b01 || a_operand !== 3'b110) begin
            errors++; $display("FAIL switch_capture: presses=%0d state=%b a=%b expected 1, 01, 110", npress, state, a_operand);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #3;
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        do_press(6, 3'b100, 4'b0001);
        checks++;
        if (state !== 2'b01 || a_operand !== 3'b100 || b_operand !== 3'b000) begin
            errors++; $display("FAIL reset_mid: state=%b a=%b b=%b expected 01, 100, 000", state, a_operand, b_operand);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int hi = $urandom_range(1, 8);
            int lo = $urandom_range(1, 8);
            for (int c = 0; c < hi + lo; c++) begin
                btn     = (c < hi);
                sw_data = 3'($urandom_range(0, 7));
                sw_op   = 4'($urandom_range(0, 15));
                clr     = ($urandom_range(0, 15) == 0);
                tick();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++; $display("FAIL random_model: got %h expected %h", dut_vec(), model_vec());
                end
            end
        end
        clr = 0; btn = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_clr_press();
        test_full_sequence();
        test_switch_changes();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
